// File: rtl/writeback_unit.sv
// Register-file writeback stage: selects ALU/PC_NEXT/CSR/LOAD data, formats loads, registers the write (latency 1).
// Backpressure: ready_o drops while a load response is outstanding; valid_i is ignored until the response arrives.
module writeback_unit #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  localparam int OFFSET_WIDTH  = $clog2(XLEN/8)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [1:0]                source_i,
  input  logic [XLEN-1:0]           alu_result_i,
  input  logic [XLEN-1:0]           pc_next_sequential_i,
  input  logic [XLEN-1:0]           csr_data_i,
  input  logic [1:0]                load_size_i,
  input  logic                      load_unsigned_i,
  input  logic [OFFSET_WIDTH-1:0]   load_offset_i,
  input  logic                      write_enable_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_address_i,
  input  logic                      load_rsp_valid_i,
  input  logic [XLEN-1:0]           load_rsp_data_i,
  output logic                      write_enable_o,
  output logic [REG_ADDR_WIDTH-1:0] write_address_o,
  output logic [XLEN-1:0]           write_data_o,
  output logic                      retire_o,
  output logic                      busy_o,
  output logic [REG_ADDR_WIDTH-1:0] pending_address_o
);

  localparam logic [1:0] SRC_ALU  = 2'd0;
  localparam logic [1:0] SRC_PC   = 2'd1;
  localparam logic [1:0] SRC_LOAD = 2'd2;

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t                    state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0] lat_rd;
  logic                      lat_we;
  logic [1:0]                lat_size;
  logic                      lat_uns;
  logic [OFFSET_WIDTH-1:0]   lat_off;

  logic                      latch_load;
  logic                      complete;
  logic                      cmp_we;
  logic [REG_ADDR_WIDTH-1:0] cmp_addr;
  logic [XLEN-1:0]           cmp_data;

  // Lane start is the offset rounded down to the access size, so misaligned offsets select the containing lane.
  function automatic logic [XLEN-1:0] format_load(
    input logic [XLEN-1:0]         raw,
    input logic [1:0]              size,
    input logic                    uns,
    input logic [OFFSET_WIDTH-1:0] off
  );
    logic [OFFSET_WIDTH-1:0] lane_byte;
    logic [XLEN-1:0]         field;
    logic [XLEN-1:0]         res;
    case (size)
      2'd0:    lane_byte = off;
      2'd1:    lane_byte = off & ~OFFSET_WIDTH'(1);
      2'd2:    lane_byte = off & ~OFFSET_WIDTH'(3);
      default: lane_byte = '0;
    endcase
    field = raw >> {lane_byte, 3'b000};
    case (size)
      2'd0: res = {{(XLEN-8){field[7] & ~uns}}, field[7:0]};
      2'd1: res = {{(XLEN-16){field[15] & ~uns}}, field[15:0]};
      2'd2: begin
        res = XLEN'(field[31:0]);
        if (!uns) res = XLEN'($signed(field[31:0]));
      end
      default: res = field;
    endcase
    return res;
  endfunction

  always_comb begin
    state_d    = state_q;
    latch_load = 1'b0;
    complete   = 1'b0;
    cmp_we     = 1'b0;
    cmp_addr   = rd_address_i;
    cmp_data   = alu_result_i;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (source_i == SRC_LOAD && !load_rsp_valid_i) begin
            latch_load = 1'b1;
            state_d    = WAIT_LOAD;
          end else begin
            complete = 1'b1;
            cmp_we   = write_enable_i;
            case (source_i)
              SRC_ALU:  cmp_data = alu_result_i;
              SRC_PC:   cmp_data = pc_next_sequential_i;
              SRC_LOAD: cmp_data = format_load(load_rsp_data_i, load_size_i,
                                               load_unsigned_i, load_offset_i);
              default:  cmp_data = csr_data_i;
            endcase
          end
        end
      end
      WAIT_LOAD: begin
        if (load_rsp_valid_i) begin
          complete = 1'b1;
          cmp_we   = lat_we;
          cmp_addr = lat_rd;
          cmp_data = format_load(load_rsp_data_i, lat_size, lat_uns, lat_off);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      lat_rd          <= '0;
      lat_we          <= 1'b0;
      lat_size        <= 2'd0;
      lat_uns         <= 1'b0;
      lat_off         <= '0;
      write_enable_o  <= 1'b0;
      write_address_o <= '0;
      write_data_o    <= '0;
      retire_o        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch_load) begin
        lat_rd   <= rd_address_i;
        lat_we   <= write_enable_i;
        lat_size <= load_size_i;
        lat_uns  <= load_unsigned_i;
        lat_off  <= load_offset_i;
      end
      // x0 is hardwired: the write is dropped but the instruction still retires.
      write_enable_o <= complete && cmp_we && (cmp_addr != '0);
      retire_o       <= complete;
      if (complete) begin
        write_address_o <= cmp_addr;
        write_data_o    <= cmp_data;
      end
    end
  end

  assign ready_o           = (state_q == IDLE);
  assign busy_o            = (state_q == WAIT_LOAD);
  assign pending_address_o = busy_o ? lat_rd : '0;

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter XLEN, default 32, meaning datapath width; legal values 32 and 64.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, meaning register address width.
REQ-003 Derived localparam OFFSET_WIDTH = $clog2(XLEN/8), meaning byte-offset width.
REQ-004 Port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst_i  input  1  reset; synchronous, active-high.
REQ-006 Port valid_i  input  1  upstream instruction valid.
REQ-007 Port ready_o  output  1  unit accepts an instruction this cycle.
REQ-008 Port source_i  input  2  writeback source: 0 ALU, 1 PC_NEXT, 2 LOAD, 3 CSR.
REQ-009 Port alu_result_i / pc_next_sequential_i / csr_data_i  input  XLEN each  candidate writeback data.
REQ-010 Port load_size_i  input  2  0 byte, 1 half, 2 word, 3 full XLEN.
REQ-011 Port load_unsigned_i  input  1  zero-extend (1) or sign-extend (0) load data.
REQ-012 Port load_offset_i  input  OFFSET_WIDTH  byte address low bits of the load.
REQ-013 Port write_enable_i  input  1  instruction writes rd.
REQ-014 Port rd_address_i  input  REG_ADDR_WIDTH  destination register.
REQ-015 Port load_rsp_valid_i  input  1  load response data valid this cycle.
REQ-016 Port load_rsp_data_i  input  XLEN  raw aligned memory word.
REQ-017 Port write_enable_o / write_address_o / write_data_o  output  1 / REG_ADDR_WIDTH / XLEN  registered register-file write.
REQ-018 Port retire_o  output  1  registered one-cycle pulse per completed instruction.
REQ-019 Port busy_o  output  1  load outstanding (state WAIT_LOAD).
REQ-020 Port pending_address_o  output  REG_ADDR_WIDTH  rd of outstanding load; 0 when not busy.

Function
REQ-021 States IDLE and WAIT_LOAD; ready_o = (state == IDLE), combinational from state only.
REQ-022 Accept = valid_i && ready_o; no accept -> next-cycle write_enable_o = 0, retire_o = 0.
REQ-023 Accept with source ALU/PC_NEXT/CSR -> next cycle write_data_o = selected input, write_address_o = rd_address_i, retire_o = 1; state stays IDLE; latency 1.
REQ-024 Accept with source LOAD and load_rsp_valid_i = 1 same cycle -> complete as REQ-023 with formatted load data; state stays IDLE.
REQ-025 Accept with source LOAD and load_rsp_valid_i = 0 -> latch rd, write_enable, size, unsigned, offset; state -> WAIT_LOAD; no write next cycle.
REQ-026 In WAIT_LOAD, load_rsp_valid_i = 1 -> next cycle write of formatted data with latched fields, retire_o = 1, state -> IDLE; valid_i ignored throughout WAIT_LOAD.
REQ-027 load_rsp_valid_i in IDLE without a LOAD accept is ignored.
REQ-028 Byte: lane = offset; half: lane = offset[OFFSET_WIDTH-1:1]; word: lane = offset[OFFSET_WIDTH-1:2]; full XLEN: offset ignored, no extension.
REQ-029 Extracted field sign- or zero-extended to XLEN per load_unsigned; word at XLEN=32 passes through unchanged.
REQ-030 write_enable_o = latched/input write_enable AND (rd != 0); write_data_o and write_address_o still update when the write is suppressed; retire_o unaffected by suppression.
REQ-031 When no completion occurs, write_data_o and write_address_o hold their previous values.
REQ-032 pending_address_o = latched rd in WAIT_LOAD, else 0.

Reset
REQ-033 rst_i high at a clock edge -> state IDLE, write_enable_o 0, write_address_o 0, write_data_o 0, retire_o 0, busy_o 0, pending_address_o 0.
REQ-034 Reset in WAIT_LOAD discards the outstanding load; a load response in the first cycle after reset produces no write.
REQ-035 Reset dominates a simultaneous accept or load response.

Verification
REQ-036 ALU: valid_i=1, source 0, alu=0x12345678, rd=5, we=1 -> next cycle we_o=1, addr 5, data 0x12345678, retire 1.
REQ-037 Load byte signed, offset 3, rsp 0x80FFFFFF same cycle, rd=7 -> next cycle data 0xFFFFFF80; unsigned -> 0x00000080.
REQ-038 Load half, offset 2, rsp 0x0000 arrives 3 cycles later -> ready_o 0 and busy_o 1 for 3 cycles, pending_address_o = rd, then write data 0x00000000 plus retire; valid_i pulses during wait are ignored.
REQ-039 PC_NEXT to rd=0, we=1 -> we_o=0, retire_o=1, data = pc_next_sequential_i.
REQ-040 Reset asserted during WAIT_LOAD with rsp the following cycle -> no write, busy_o 0, ready_o 1.
REQ-041 XLEN=64 word load, offset 4, rsp 0x80000000_00000000 -> data 0xFFFFFFFF_80000000.
